// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives rows one-hot, samples columns at the end of each
// row slot, debounces whole-scan results and reports the held key plus a press pulse.
module keypad_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [4:0] key,
    output logic [4:0] key_pulse
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W  = $clog2(DEBOUNCE_N) + 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(DEBOUNCE_N - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        row_q, row_d;
    logic [4:0]        acc_q, acc_d;
    logic [4:0]        prev_q, prev_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [4:0]        key_q, key_d;
    logic [4:0]        pulse_q, pulse_d;
    state_t            state_q, state_d;

    logic       sample;
    logic       scan_done;
    logic [1:0] col_idx;
    logic [4:0] result;
    logic       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= '0;
            row_q    <= '0;
            acc_q    <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            key_q    <= '0;
            pulse_q  <= '0;
            state_q  <= RELEASED;
        end else begin
            slot_q   <= slot_d;
            row_q    <= row_d;
            acc_q    <= acc_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            key_q    <= key_d;
            pulse_q  <= pulse_d;
            state_q  <= state_d;
        end
    end

    // Lowest active column wins within a row.
    always_comb begin
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_col[i]) begin
                col_idx = 2'(i);
            end
        end
    end

    // Rows are visited in ascending order, so the first hit of a scan is the lowest code.
    always_comb begin
        sample    = (slot_q == SLOT_LAST);
        scan_done = sample && (row_q == 2'd3);
        if (acc_q[4]) begin
            result = acc_q;
        end else if (|key_col) begin
            result = {1'b1, row_q, col_idx};
        end else begin
            result = 5'h00;
        end
        slot_d = sample ? '0 : slot_q + 1'b1;
        row_d  = sample ? row_q + 2'd1 : row_q;
        if (scan_done) begin
            acc_d = 5'h00;
        end else if (sample) begin
            acc_d = result;
        end else begin
            acc_d = acc_q;
        end
    end

    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        if (scan_done) begin
            if (result == prev_q) begin
                stable_d = (stable_q < STB_MAX) ? stable_q + 1'b1 : stable_q;
            end else begin
                stable_d = '0;
                prev_d   = result;
            end
        end
        accept = scan_done && (stable_d == STB_MAX) && (result != key_q);
    end

    always_comb begin
        state_d = state_q;
        if (scan_done) begin
            if (accept) begin
                state_d = result[4] ? PRESSED : RELEASED;
            end else begin
                case (state_q)
                    RELEASED:    if (result[4])        state_d = PRESS_CHK;
                    PRESS_CHK:   if (!result[4])       state_d = RELEASED;
                    PRESSED:     if (result != key_q)  state_d = RELEASE_CHK;
                    RELEASE_CHK: if (result == key_q)  state_d = PRESSED;
                    default:                           state_d = RELEASED;
                endcase
            end
        end
    end

    // A release is accepted silently; only a valid new code pulses.
    always_comb begin
        key_d   = accept ? result : key_q;
        pulse_d = (accept && result[4]) ? result : 5'h00;
    end

    assign key_row   = 4'b0001 << row_q;
    assign key       = key_q;
    assign key_pulse = pulse_q;

endmodule
